// File: rtl/microcode_seq_pkg.sv
// Shared definitions for the microcode sequencer: state encoding, opcodes,
// ALU function codes and the single-bit datapath control word.
package microcode_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [3:0] OPC_ADD = 4'h0;
  localparam logic [3:0] OPC_SUB = 4'h1;
  localparam logic [3:0] OPC_AND = 4'h2;
  localparam logic [3:0] OPC_OR  = 4'h3;
  localparam logic [3:0] OPC_XOR = 4'h4;
  localparam logic [3:0] OPC_NOT = 4'h5;
  localparam logic [3:0] OPC_MOV = 4'h6;
  localparam logic [3:0] OPC_NOP = 4'h7;
  localparam logic [3:0] OPC_LD  = 4'h8;
  localparam logic [3:0] OPC_ST  = 4'h9;
  localparam logic [3:0] OPC_LDI = 4'hA;
  localparam logic [3:0] OPC_RSV = 4'hB;
  localparam logic [3:0] OPC_BRZ = 4'hC;
  localparam logic [3:0] OPC_BRN = 4'hD;
  localparam logic [3:0] OPC_BRO = 4'hE;
  localparam logic [3:0] OPC_BRA = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic ir_load;
    logic pc_en;
    logic pc_load;
    logic ie;
    logic write;
    logic reada;
    logic readb;
    logic en;
    logic oe;
    logic bypassa;
    logic bypassb;
    logic mov_sel;
  } ctl_t;

  function automatic logic is_mem_op(input logic [3:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ST);
  endfunction

endpackage

// File: rtl/microcode_seq_decode.sv
// Combinational control decode: (state, IR fields, flags, mem_ready) -> control word.
// kill forces every control low so reset removes requests the same instant.
module microcode_decode
  import microcode_seq_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int REG_AW = 3
) (
  input  logic              kill,
  input  state_t            state,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_AW-1:0] dst,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  input  logic              o_flag,
  input  logic              z_flag,
  input  logic              n_flag,
  input  logic              mem_ready,
  output ctl_t              ctl,
  output logic [2:0]        op,
  output logic [REG_AW-1:0] waddr,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb
);

  logic [3:0] opc;
  assign opc = 4'(opcode);

  always_comb begin
    ctl   = '0;
    op    = '0;
    waddr = '0;
    ra    = '0;
    rb    = '0;
    if (!kill) begin
      case (state)
        ST_FETCH: begin
          ctl.mem_req = 1'b1;
          ctl.ir_load = mem_ready;
          ctl.pc_en   = mem_ready;
        end
        ST_EXEC: begin
          case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_NOT: begin
              ctl.reada = 1'b1;
              ctl.readb = 1'b1;
              ra        = src_a;
              rb        = src_b;
              op        = opc[2:0];
              ctl.write = 1'b1;
              waddr     = dst;
              ctl.en    = 1'b1;
            end
            OPC_MOV: begin
              ctl.reada   = 1'b1;
              ra          = src_a;
              ctl.mov_sel = 1'b1;
              ctl.write   = 1'b1;
              waddr       = dst;
            end
            OPC_LDI: begin
              ctl.ie    = 1'b1;
              ctl.write = 1'b1;
              waddr     = dst;
            end
            // LD computes its address by passing srcA straight through the ALU
            OPC_LD: begin
              ctl.reada   = 1'b1;
              ra          = src_a;
              ctl.bypassb = 1'b1;
              op          = ALU_MOV;
              ctl.oe      = 1'b1;
            end
            OPC_ST: begin
              ctl.reada = 1'b1;
              ctl.readb = 1'b1;
              ra        = src_a;
              rb        = src_b;
              ctl.oe    = 1'b1;
            end
            OPC_BRZ: ctl.pc_load = z_flag;
            OPC_BRN: ctl.pc_load = n_flag;
            OPC_BRO: ctl.pc_load = o_flag;
            OPC_BRA: ctl.pc_load = 1'b1;
            default: ;
          endcase
        end
        ST_MEM: begin
          ctl.mem_req  = 1'b1;
          ctl.mem_we   = (opc == OPC_ST);
          ctl.addr_sel = 1'b1;
          ctl.oe       = 1'b1;
        end
        ST_WB: begin
          ctl.ie    = 1'b1;
          ctl.write = 1'b1;
          waddr     = dst;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/microcode_seq.sv
// Multi-cycle microcode sequencer top: state register, instruction register
// and next-state logic; control outputs come from microcode_decode.
module microcode_seq
  import microcode_seq_pkg::*;
#(
  parameter  int OP_W    = 4,
  parameter  int REG_AW  = 3,
  parameter  int INSTR_W = 16,
  localparam int IMM_W   = INSTR_W - OP_W - REG_AW,
  localparam int OFS_W   = INSTR_W - OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] din,
  input  logic               mem_ready,
  input  logic               o_flag,
  input  logic               z_flag,
  input  logic               n_flag,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               ir_load,
  output logic               pc_en,
  output logic               pc_load,
  output logic [OFS_W-1:0]   offset,
  output logic [IMM_W-1:0]   imm,
  output logic [2:0]         op,
  output logic [REG_AW-1:0]  waddr,
  output logic [REG_AW-1:0]  ra,
  output logic [REG_AW-1:0]  rb,
  output logic               ie,
  output logic               write,
  output logic               reada,
  output logic               readb,
  output logic               en,
  output logic               oe,
  output logic               bypassa,
  output logic               bypassb,
  output logic               mov_sel
);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  ctl_t               ctl;
  logic [OP_W-1:0]    ir_op;
  logic [REG_AW-1:0]  ir_dst, ir_a, ir_b;
  logic [3:0]         opc;

  assign ir_op  = ir[INSTR_W-1 -: OP_W];
  assign ir_dst = ir[INSTR_W-OP_W-1 -: REG_AW];
  assign ir_a   = ir[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
  assign ir_b   = ir[INSTR_W-OP_W-2*REG_AW-1 -: REG_AW];
  assign opc    = 4'(ir_op);

  assign offset = ir[OFS_W-1:0];
  assign imm    = ir[IMM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ir <= '0;
    else if (ctl.ir_load) ir <= din;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (mem_ready) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = is_mem_op(opc) ? ST_MEM : ST_FETCH;
      ST_MEM:   if (mem_ready) state_nxt = (opc == OPC_LD) ? ST_WB : ST_FETCH;
      ST_WB:    state_nxt = ST_FETCH;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  microcode_decode #(
    .OP_W   (OP_W),
    .REG_AW (REG_AW)
  ) u_decode (
    .kill      (rst),
    .state     (state),
    .opcode    (ir_op),
    .dst       (ir_dst),
    .src_a     (ir_a),
    .src_b     (ir_b),
    .o_flag    (o_flag),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .mem_ready (mem_ready),
    .ctl       (ctl),
    .op        (op),
    .waddr     (waddr),
    .ra        (ra),
    .rb        (rb)
  );

  assign mem_req  = ctl.mem_req;
  assign mem_we   = ctl.mem_we;
  assign addr_sel = ctl.addr_sel;
  assign ir_load  = ctl.ir_load;
  assign pc_en    = ctl.pc_en;
  assign pc_load  = ctl.pc_load;
  assign ie       = ctl.ie;
  assign write    = ctl.write;
  assign reada    = ctl.reada;
  assign readb    = ctl.readb;
  assign en       = ctl.en;
  assign oe       = ctl.oe;
  assign bypassa  = ctl.bypassa;
  assign bypassb  = ctl.bypassb;
  assign mov_sel  = ctl.mov_sel;

endmodule

// File: tb/tb_microcode_seq.sv
// Self-checking bench for microcode_seq: directed table, hand-written reset and
// wide-parameter sequences, and random instructions against a per-instruction step model.
module tb_microcode_seq;

  localparam int IMM_W = 9;
  localparam int OFS_W = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        mem_ready = 1'b0;
  logic        o_flag = 1'b0, z_flag = 1'b0, n_flag = 1'b0;

  logic             mem_req, mem_we, addr_sel, ir_load, pc_en, pc_load;
  logic [OFS_W-1:0] offset;
  logic [IMM_W-1:0] imm;
  logic [2:0]       op, waddr, ra, rb;
  logic             ie, write, reada, readb, en, oe, bypassa, bypassb, mov_sel;

  logic [19:0] din2 = '0;
  logic        mem_ready2 = 1'b0;
  logic        mem_req2, mem_we2, addr_sel2, ir_load2, pc_en2, pc_load2;
  logic [15:0] offset2;
  logic [11:0] imm2;
  logic [2:0]  op2;
  logic [3:0]  waddr2, ra2, rb2;
  logic        ie2, write2, reada2, readb2, en2, oe2, bypassa2, bypassb2, mov_sel2;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  microcode_seq dut (
    .clk(clk), .rst(rst), .din(din), .mem_ready(mem_ready),
    .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_en(pc_en), .pc_load(pc_load), .offset(offset), .imm(imm), .op(op),
    .waddr(waddr), .ra(ra), .rb(rb), .ie(ie), .write(write), .reada(reada),
    .readb(readb), .en(en), .oe(oe), .bypassa(bypassa), .bypassb(bypassb),
    .mov_sel(mov_sel)
  );

  microcode_seq #(.OP_W(4), .REG_AW(4), .INSTR_W(20)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .mem_ready(mem_ready2),
    .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag),
    .mem_req(mem_req2), .mem_we(mem_we2), .addr_sel(addr_sel2), .ir_load(ir_load2),
    .pc_en(pc_en2), .pc_load(pc_load2), .offset(offset2), .imm(imm2), .op(op2),
    .waddr(waddr2), .ra(ra2), .rb(rb2), .ie(ie2), .write(write2), .reada(reada2),
    .readb(readb2), .en(en2), .oe(oe2), .bypassa(bypassa2), .bypassb(bypassb2),
    .mov_sel(mov_sel2)
  );

  typedef struct packed {
    logic mem_req, mem_we, addr_sel, ir_load, pc_en, pc_load;
    logic ie, write, reada, readb, en, oe, bypassa, bypassb, mov_sel;
    logic [2:0] op;
    logic [2:0] waddr;
    logic [2:0] ra;
    logic [2:0] rb;
  } cw_t;

  typedef struct packed {
    cw_t  cw;
    logic mem;
  } step_t;

  typedef step_t step_q_t[$];

  typedef struct {
    string       name;
    logic [15:0] ins;
    logic [2:0]  flg;   // {o, z, n}
    int          fw;
    int          mw;
    int          lat;
  } vec_t;

  function automatic cw_t cur_cw();
    cw_t c;
    c.mem_req = mem_req;   c.mem_we = mem_we;   c.addr_sel = addr_sel;
    c.ir_load = ir_load;   c.pc_en = pc_en;     c.pc_load = pc_load;
    c.ie = ie;             c.write = write;     c.reada = reada;
    c.readb = readb;       c.en = en;           c.oe = oe;
    c.bypassa = bypassa;   c.bypassb = bypassb; c.mov_sel = mov_sel;
    c.op = op; c.waddr = waddr; c.ra = ra; c.rb = rb;
    return c;
  endfunction

  function automatic logic [14:0] ctl2();
    return {mem_req2, mem_we2, addr_sel2, ir_load2, pc_en2, pc_load2, ie2, write2,
            reada2, readb2, en2, oe2, bypassa2, bypassb2, mov_sel2};
  endfunction

  function automatic step_t mk(input cw_t c, input logic m);
    step_t s;
    s.cw  = c;
    s.mem = m;
    return s;
  endfunction

  function automatic cw_t fetch_cw(input logic rdy);
    cw_t c = '0;
    c.mem_req = 1'b1;
    c.ir_load = rdy;
    c.pc_en   = rdy;
    return c;
  endfunction

  // Expected control word for every cycle after the fetch, per instruction class.
  function automatic step_q_t model_steps(input logic [15:0] ins, input logic [2:0] flg);
    step_q_t    q;
    cw_t        c;
    logic [3:0] opc;
    logic [2:0] d, a, b;
    logic       tk;
    opc = ins[15:12]; d = ins[11:9]; a = ins[8:6]; b = ins[5:3];
    c = '0;
    case (opc)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        c.reada = 1; c.readb = 1; c.ra = a; c.rb = b; c.op = opc[2:0];
        c.write = 1; c.waddr = d; c.en = 1;
        q.push_back(mk(c, 1'b0));
      end
      4'h6: begin
        c.reada = 1; c.ra = a; c.mov_sel = 1; c.write = 1; c.waddr = d;
        q.push_back(mk(c, 1'b0));
      end
      4'hA: begin
        c.ie = 1; c.write = 1; c.waddr = d;
        q.push_back(mk(c, 1'b0));
      end
      4'h8: begin
        c.reada = 1; c.ra = a; c.bypassb = 1; c.op = 3'b110; c.oe = 1;
        q.push_back(mk(c, 1'b0));
        c = '0; c.mem_req = 1; c.addr_sel = 1; c.oe = 1;
        q.push_back(mk(c, 1'b1));
        c = '0; c.ie = 1; c.write = 1; c.waddr = d;
        q.push_back(mk(c, 1'b0));
      end
      4'h9: begin
        c.reada = 1; c.readb = 1; c.ra = a; c.rb = b; c.oe = 1;
        q.push_back(mk(c, 1'b0));
        c = '0; c.mem_req = 1; c.mem_we = 1; c.addr_sel = 1; c.oe = 1;
        q.push_back(mk(c, 1'b1));
      end
      4'hC, 4'hD, 4'hE, 4'hF: begin
        tk = (opc == 4'hC) ? flg[1] : (opc == 4'hD) ? flg[0] : (opc == 4'hE) ? flg[2] : 1'b1;
        c.pc_load = tk;
        q.push_back(mk(c, 1'b0));
      end
      default: q.push_back(mk(c, 1'b0));
    endcase
    return q;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exec_instr(input string nm, input logic [15:0] ins, input logic [2:0] flg,
                            input int fw, input int mw);
    step_q_t q;
    q = model_steps(ins, flg);
    {o_flag, z_flag, n_flag} = flg;
    for (int i = 0; i <= fw; i++) begin
      @(negedge clk);
      mem_ready = (i == fw);
      din = (i == fw) ? ins : 16'($urandom);
      #1;
      check({nm, "/fetch"}, 64'(cur_cw()), 64'(fetch_cw(mem_ready)));
    end
    foreach (q[k]) begin
      int reps = q[k].mem ? mw : 0;
      for (int r = 0; r <= reps; r++) begin
        @(negedge clk);
        din = 16'($urandom);
        mem_ready = q[k].mem ? (r == reps) : 1'($urandom);
        #1;
        check($sformatf("%s/step%0d", nm, k), 64'(cur_cw()), 64'(q[k].cw));
        if (k == 0 && r == 0) begin
          check({nm, "/offset"}, 64'(offset), 64'(ins[11:0]));
          check({nm, "/imm"}, 64'(imm), 64'(ins[8:0]));
        end
      end
    end
  endtask

  // Cycles from the accepted fetch until the sequencer is fetching again (zero-wait memory).
  task automatic measure_lat(input logic [15:0] ins, output int cyc);
    @(negedge clk);
    din = ins;
    mem_ready = 1'b1;
    cyc = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      din = '0;
      #1;
      if (mem_req && !addr_sel) break;
      mem_ready = 1'b1;
      cyc++;
    end
  endtask

  vec_t        vecs[$];
  logic [15:0] rins;
  int          lat;
  cw_t         e;

  initial begin
    vecs.push_back('{"add",    16'b0000_000_001_101_000, 3'b000, 0, 0, 2});
    vecs.push_back('{"ldi",    16'b1010_001_000111100,   3'b000, 0, 0, 2});
    vecs.push_back('{"ld_wait",16'b1000_010_011_000_000, 3'b000, 1, 3, 4});
    vecs.push_back('{"st",     16'b1001_011_100_101_000, 3'b111, 0, 2, 3});
    vecs.push_back('{"brz_t",  16'hCFFE,                 3'b010, 0, 0, 2});
    vecs.push_back('{"brz_nt", 16'hCFFE,                 3'b101, 0, 0, 2});
    vecs.push_back('{"brn_t",  16'hD005,                 3'b001, 0, 0, 2});
    vecs.push_back('{"bro_nt", 16'hE010,                 3'b011, 0, 0, 2});
    vecs.push_back('{"bra",    16'hF123,                 3'b000, 0, 0, 2});
    vecs.push_back('{"mov",    16'b0110_101_110_000_000, 3'b000, 0, 0, 2});
    vecs.push_back('{"not",    16'b0101_111_010_011_000, 3'b000, 0, 0, 2});
    vecs.push_back('{"nop",    16'h7ABC,                 3'b111, 0, 0, 2});
    vecs.push_back('{"rsv",    16'hB5A5,                 3'b000, 0, 0, 2});
    vecs.push_back('{"sub",    16'b0001_100_111_001_000, 3'b000, 2, 0, 2});

    // Reset: everything low while rst is high, fetch request after release.
    #1 rst = 1'b1;
    #1;
    check("rst/cw", 64'(cur_cw()), 64'(0));
    check("rst/offset", 64'(offset), 64'(0));
    check("rst/imm", 64'(imm), 64'(0));
    check("rst/dut2_ctl", 64'(ctl2()), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst/release", 64'(cur_cw()), 64'(fetch_cw(1'b0)));

    // Wide-parameter instance: opcode 4, reg 4, instr 20 bits.
    @(negedge clk);
    din2 = {4'h1, 4'd9, 4'd12, 4'd3, 4'hA};
    mem_ready2 = 1'b1;
    #1;
    check("w/fetch_ir_load", 64'(ir_load2), 64'(1));
    @(negedge clk);
    mem_ready2 = 1'b0;
    din2 = '0;
    #1;
    e = '0; e.reada = 1; e.readb = 1; e.write = 1; e.en = 1;
    check("w/alu_ctl", 64'(ctl2()), 64'(e[26:12]));
    check("w/alu_fields", 64'({op2, waddr2, ra2, rb2}), 64'({3'd1, 4'd9, 4'd12, 4'd3}));
    check("w/offset", 64'(offset2), 64'(16'h9C3A));
    check("w/imm", 64'(imm2), 64'(12'hC3A));
    @(negedge clk);
    din2 = {4'hA, 4'd5, 12'hABC};
    mem_ready2 = 1'b1;
    @(negedge clk);
    mem_ready2 = 1'b0;
    #1;
    e = '0; e.ie = 1; e.write = 1;
    check("w/ldi_ctl", 64'(ctl2()), 64'(e[26:12]));
    check("w/ldi_waddr", 64'(waddr2), 64'(5));
    check("w/ldi_imm", 64'(imm2), 64'(12'hABC));

    // Directed table: per-cycle controls plus end-to-end latency.
    foreach (vecs[i]) begin
      exec_instr(vecs[i].name, vecs[i].ins, vecs[i].flg, vecs[i].fw, vecs[i].mw);
      measure_lat(vecs[i].ins, lat);
      check({vecs[i].name, "/latency"}, 64'(lat), 64'(vecs[i].lat));
    end

    // Reset asserted in the middle of a stalled store.
    {o_flag, z_flag, n_flag} = 3'b000;
    @(negedge clk);
    din = 16'b1001_001_010_011_000;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("strst/mem_req_we", 64'({mem_req, mem_we, addr_sel}), 64'(3'b111));
    #2 rst = 1'b1;
    #1;
    check("strst/cw", 64'(cur_cw()), 64'(0));
    check("strst/offset", 64'(offset), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("strst/release", 64'(cur_cw()), 64'(fetch_cw(1'b0)));

    // Random instructions, waits and flags.
    for (int i = 0; i < 150; i++) begin
      rins = 16'($urandom);
      exec_instr($sformatf("rnd%0d_%h", i, rins), rins, 3'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1 ms, want finish");
    $fatal(1);
  end

endmodule
